// File: rtl/thcomptop_if.sv
// Handshake and cfg-bus bundle between the EMA stage, the threshold comparator
// and the control block; the comparator connects through the slave modport.
interface thcomptop_if #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
);
    logic              ematop_thcomptop_start;
    logic [WIDTH-1:0]  ematop_thcomptop_data;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [WIDTH-1:0]  cfg_data_in;
    logic [WIDTH-1:0]  thcompregs_ctrltop_cfg_data_out0;
    logic [WIDTH-1:0]  thcompregs_ctrltop_cfg_data_out1;
    logic [WIDTH-1:0]  thcompregs_ctrltop_cfg_data_out2;
    logic              thcomptop_ctrltop_start;
    logic [WIDTH-1:0]  thcomptop_ctrltop_data;
    logic              thcomptop_ctrltop_detect;
    logic              thcomptop_ctrltop_event;
    logic              thcomptop_ctrltop_overrun;

    modport slave (
        input  ematop_thcomptop_start, ematop_thcomptop_data,
        input  cfg_we, cfg_addr, cfg_data_in,
        output thcompregs_ctrltop_cfg_data_out0, thcompregs_ctrltop_cfg_data_out1,
        output thcompregs_ctrltop_cfg_data_out2,
        output thcomptop_ctrltop_start, thcomptop_ctrltop_data,
        output thcomptop_ctrltop_detect, thcomptop_ctrltop_event,
        output thcomptop_ctrltop_overrun
    );

    modport master (
        output ematop_thcomptop_start, ematop_thcomptop_data,
        output cfg_we, cfg_addr, cfg_data_in,
        input  thcompregs_ctrltop_cfg_data_out0, thcompregs_ctrltop_cfg_data_out1,
        input  thcompregs_ctrltop_cfg_data_out2,
        input  thcomptop_ctrltop_start, thcomptop_ctrltop_data,
        input  thcomptop_ctrltop_detect, thcomptop_ctrltop_event,
        input  thcomptop_ctrltop_overrun
    );
endinterface

// File: rtl/thcomptop.sv
// Threshold comparator with hysteresis and hold-count debounce; one result
// pulse two cycles after each accepted EMA sample, thresholds set over cfg bus.
module thcomptop #(
    parameter int              WIDTH      = 16,
    parameter int              ADDR_W     = 4,
    parameter logic [WIDTH-1:0] THR_HI_RST = 16'h8000,
    parameter logic [WIDTH-1:0] THR_LO_RST = 16'h6000,
    parameter logic [WIDTH-1:0] HOLD_RST   = 16'd1
) (
    input  logic         clk,
    input  logic         rst,
    thcomptop_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_CMP, S_OUT} state_t;

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_thr_hi, r_thr_lo, r_hold;
    logic [WIDTH-1:0] r_sample, w_sample_next;
    logic [WIDTH-1:0] r_above_cnt, w_above_next;
    logic [WIDTH-1:0] r_below_cnt, w_below_next;
    logic             r_detect, w_detect_next;
    logic             r_event, w_event_next;
    logic             r_start_out, w_start_next;
    logic [WIDTH-1:0] r_data_out, w_data_next;
    logic             r_overrun, w_overrun_next;
    logic [WIDTH-1:0] w_h, w_above_inc, w_below_inc;
    logic             w_cfg_clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sample    <= '0;
            r_above_cnt <= '0;
            r_below_cnt <= '0;
            r_detect    <= 1'b0;
            r_event     <= 1'b0;
            r_start_out <= 1'b0;
            r_data_out  <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sample    <= w_sample_next;
            r_above_cnt <= w_above_next;
            r_below_cnt <= w_below_next;
            r_detect    <= w_detect_next;
            r_event     <= w_event_next;
            r_start_out <= w_start_next;
            r_data_out  <= w_data_next;
            r_overrun   <= w_overrun_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thr_hi <= THR_HI_RST;
            r_thr_lo <= THR_LO_RST;
            r_hold   <= HOLD_RST;
        end else if (bus.cfg_we) begin
            case (bus.cfg_addr)
                ADDR_W'(0): r_thr_hi <= bus.cfg_data_in;
                ADDR_W'(1): r_thr_lo <= bus.cfg_data_in;
                ADDR_W'(2): r_hold   <= bus.cfg_data_in;
                default: ;
            endcase
        end
    end

    // HOLD=0 behaves as 1; counters stick at all-ones instead of wrapping.
    assign w_h         = (r_hold == '0) ? ONE : r_hold;
    assign w_above_inc = (r_above_cnt == ONES) ? r_above_cnt : r_above_cnt + ONE;
    assign w_below_inc = (r_below_cnt == ONES) ? r_below_cnt : r_below_cnt + ONE;
    assign w_cfg_clr   = bus.cfg_we && (bus.cfg_addr == ADDR_W'(3));

    // A start outside IDLE is dropped; setting overrun beats a same-cycle clear.
    always_comb begin
        w_overrun_next = r_overrun;
        if (bus.ematop_thcomptop_start && (r_state != S_IDLE))
            w_overrun_next = 1'b1;
        else if (w_cfg_clr)
            w_overrun_next = 1'b0;
    end

    always_comb begin
        w_state_next  = r_state;
        w_sample_next = r_sample;
        w_above_next  = r_above_cnt;
        w_below_next  = r_below_cnt;
        w_detect_next = r_detect;
        w_event_next  = 1'b0;
        w_start_next  = 1'b0;
        w_data_next   = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.ematop_thcomptop_start) begin
                    w_sample_next = bus.ematop_thcomptop_data;
                    w_state_next  = S_CMP;
                end
            end
            S_CMP: begin
                w_state_next = S_OUT;
                w_start_next = 1'b1;
                w_data_next  = r_sample;
                if (!r_detect) begin
                    if (r_sample >= r_thr_hi) begin
                        if (w_above_inc >= w_h) begin
                            w_detect_next = 1'b1;
                            w_event_next  = 1'b1;
                            w_above_next  = '0;
                        end else begin
                            w_above_next  = w_above_inc;
                        end
                    end else begin
                        w_above_next = '0;
                    end
                end else begin
                    if (r_sample < r_thr_lo) begin
                        if (w_below_inc >= w_h) begin
                            w_detect_next = 1'b0;
                            w_event_next  = 1'b1;
                            w_below_next  = '0;
                        end else begin
                            w_below_next  = w_below_inc;
                        end
                    end else begin
                        w_below_next = '0;
                    end
                end
            end
            S_OUT:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign bus.thcompregs_ctrltop_cfg_data_out0 = r_thr_hi;
    assign bus.thcompregs_ctrltop_cfg_data_out1 = r_thr_lo;
    assign bus.thcompregs_ctrltop_cfg_data_out2 = r_hold;
    assign bus.thcomptop_ctrltop_start          = r_start_out;
    assign bus.thcomptop_ctrltop_data           = r_data_out;
    assign bus.thcomptop_ctrltop_detect         = r_detect;
    assign bus.thcomptop_ctrltop_event          = r_event;
    assign bus.thcomptop_ctrltop_overrun        = r_overrun;
endmodule

// File: tb/tb_thcomptop.sv
// Directed bench for thcomptop: reset defaults, hysteresis, debounce, overrun,
// config timing and mid-operation reset, with hand-computed expectations.
module tb_thcomptop;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    thcomptop_if #(.WIDTH(16), .ADDR_W(4)) bus ();

    thcomptop #(
        .WIDTH(16), .ADDR_W(4),
        .THR_HI_RST(16'h8000), .THR_LO_RST(16'h6000), .HOLD_RST(16'd1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = addr;
        bus.cfg_data_in = data;
        tick();
        bus.cfg_we      = 1'b0;
        $display("cfg write addr %0d data %04h", addr, data);
    endtask

    // Drive one sample and check the result pulse two cycles later.
    task automatic send_chk(input logic [15:0] data, input logic exp_det, input logic exp_ev);
        bus.ematop_thcomptop_start = 1'b1;
        bus.ematop_thcomptop_data  = data;
        tick();
        bus.ematop_thcomptop_start = 1'b0;
        bus.ematop_thcomptop_data  = '0;
        check("cmp_start_low", 32'(bus.thcomptop_ctrltop_start), 32'd0);
        tick();
        check("out_start",  32'(bus.thcomptop_ctrltop_start),  32'd1);
        check("out_data",   32'(bus.thcomptop_ctrltop_data),   32'(data));
        check("out_detect", 32'(bus.thcomptop_ctrltop_detect), 32'(exp_det));
        check("out_event",  32'(bus.thcomptop_ctrltop_event),  32'(exp_ev));
        $display("sample %04h -> detect %0d event %0d", data,
                 bus.thcomptop_ctrltop_detect, bus.thcomptop_ctrltop_event);
        tick();
        check("idle_start", 32'(bus.thcomptop_ctrltop_start), 32'd0);
        check("idle_data",  32'(bus.thcomptop_ctrltop_data),  32'd0);
    endtask

    task automatic check_defaults(input string tag);
        check({tag, "_out0"},    32'(bus.thcompregs_ctrltop_cfg_data_out0), 32'h8000);
        check({tag, "_out1"},    32'(bus.thcompregs_ctrltop_cfg_data_out1), 32'h6000);
        check({tag, "_out2"},    32'(bus.thcompregs_ctrltop_cfg_data_out2), 32'h0001);
        check({tag, "_start"},   32'(bus.thcomptop_ctrltop_start),   32'd0);
        check({tag, "_data"},    32'(bus.thcomptop_ctrltop_data),    32'd0);
        check({tag, "_detect"},  32'(bus.thcomptop_ctrltop_detect),  32'd0);
        check({tag, "_event"},   32'(bus.thcomptop_ctrltop_event),   32'd0);
        check({tag, "_overrun"}, 32'(bus.thcomptop_ctrltop_overrun), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus.ematop_thcomptop_start = 1'b0;
        bus.ematop_thcomptop_data  = '0;
        bus.cfg_we      = 1'b0;
        bus.cfg_addr    = '0;
        bus.cfg_data_in = '0;

        // Reset defaults
        tick(); tick();
        check_defaults("rst");
        rst = 1'b0;
        tick();
        $display("reset released");

        // Basic hysteresis with HOLD=1
        send_chk(16'h9000, 1'b1, 1'b1);
        send_chk(16'h7000, 1'b1, 1'b0);
        send_chk(16'h5000, 1'b0, 1'b1);

        // Debounce with HOLD=3; the low sample restarts the count
        cfg_write(4'd2, 16'd3);
        check("hold3", 32'(bus.thcompregs_ctrltop_cfg_data_out2), 32'd3);
        send_chk(16'h9000, 1'b0, 1'b0);
        send_chk(16'h9000, 1'b0, 1'b0);
        send_chk(16'h1000, 1'b0, 1'b0);
        send_chk(16'h9000, 1'b0, 1'b0);
        send_chk(16'h9000, 1'b0, 1'b0);
        send_chk(16'h9000, 1'b1, 1'b1);
        cfg_write(4'd2, 16'd1);
        send_chk(16'h1000, 1'b0, 1'b1);

        // Overrun: second start lands in CMP and is dropped
        bus.ematop_thcomptop_start = 1'b1;
        bus.ematop_thcomptop_data  = 16'h2000;
        tick();
        bus.ematop_thcomptop_data  = 16'h1234;
        tick();
        bus.ematop_thcomptop_start = 1'b0;
        bus.ematop_thcomptop_data  = '0;
        check("ovr_start",   32'(bus.thcomptop_ctrltop_start),   32'd1);
        check("ovr_data",    32'(bus.thcomptop_ctrltop_data),    32'h2000);
        check("ovr_flag",    32'(bus.thcomptop_ctrltop_overrun), 32'd1);
        $display("overrun sample %04h overrun %0d", bus.thcomptop_ctrltop_data,
                 bus.thcomptop_ctrltop_overrun);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ovr_no_pulse", 32'(bus.thcomptop_ctrltop_start), 32'd0);
        end
        check("ovr_sticky", 32'(bus.thcomptop_ctrltop_overrun), 32'd1);
        cfg_write(4'd3, 16'hFFFF);
        check("ovr_clear", 32'(bus.thcomptop_ctrltop_overrun), 32'd0);
        check("ovr_clr_hi", 32'(bus.thcompregs_ctrltop_cfg_data_out0), 32'h8000);

        // THR_HI written during CMP: the old threshold decides this sample
        bus.ematop_thcomptop_start = 1'b1;
        bus.ematop_thcomptop_data  = 16'h8800;
        tick();
        bus.ematop_thcomptop_start = 1'b0;
        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = 4'd0;
        bus.cfg_data_in = 16'h9000;
        tick();
        bus.cfg_we = 1'b0;
        check("cfg_cmp_start",  32'(bus.thcomptop_ctrltop_start),  32'd1);
        check("cfg_cmp_detect", 32'(bus.thcomptop_ctrltop_detect), 32'd1);
        check("cfg_cmp_event",  32'(bus.thcomptop_ctrltop_event),  32'd1);
        check("cfg_cmp_hi",     32'(bus.thcompregs_ctrltop_cfg_data_out0), 32'h9000);
        $display("sample 8800 with THR_HI change -> detect %0d", bus.thcomptop_ctrltop_detect);
        tick();

        // HOLD=0 acts as 1
        cfg_write(4'd2, 16'd0);
        check("hold0", 32'(bus.thcompregs_ctrltop_cfg_data_out2), 32'd0);
        send_chk(16'h5000, 1'b0, 1'b1);
        send_chk(16'h9800, 1'b1, 1'b1);
        send_chk(16'h8800, 1'b1, 1'b0);

        // Unmapped address leaves every register alone
        cfg_write(4'd5, 16'hFFFF);
        check("a5_out0", 32'(bus.thcompregs_ctrltop_cfg_data_out0), 32'h9000);
        check("a5_out1", 32'(bus.thcompregs_ctrltop_cfg_data_out1), 32'h6000);
        check("a5_out2", 32'(bus.thcompregs_ctrltop_cfg_data_out2), 32'h0000);

        // Reset in the CMP cycle aborts the sample
        bus.ematop_thcomptop_start = 1'b1;
        bus.ematop_thcomptop_data  = 16'h1000;
        tick();
        bus.ematop_thcomptop_start = 1'b0;
        bus.ematop_thcomptop_data  = '0;
        rst = 1'b1;
        #1;
        check_defaults("midrst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_pulse", 32'(bus.thcomptop_ctrltop_start), 32'd0);
        end
        $display("mid-operation reset done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
